// File: rtl/gpu_sc_top.sv
// Single-cycle, single-thread 16-bit compute core: PC, instruction memory, register file,
// ALU and word-addressed data memory; one instruction fetched, executed and retired per clock.
module gpu_sc_top #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256,
  parameter int NUM_REGS   = 16,
  parameter int DATA_W     = 16
) (
  input logic clk,
  input logic reset
);

  localparam int PC_W = $clog2(IMEM_DEPTH);
  localparam int DM_W = $clog2(DMEM_DEPTH);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_LW  = 4'd6;
  localparam logic [3:0] OP_SW  = 4'd7;

  // Storage arrays are preloaded hierarchically by the environment.
  logic [31:0]       imem [IMEM_DEPTH];
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];

  logic [PC_W-1:0]          pc;
  logic [31:0]              instr;
  logic [3:0]               opcode;
  logic [3:0]               rd;
  logic [3:0]               rs2;
  logic [3:0]               rs1;
  logic [DATA_W-1:0]        imm;
  logic signed [DATA_W-1:0] op_a;
  logic signed [DATA_W-1:0] op_b;
  logic signed [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0]        eff_addr;
  logic [DATA_W-1:0]        mem_rdata;
  logic [DM_W-1:0]          dmem_idx;
  logic                     rf_we;
  logic                     mem_we;
  logic                     unused_addr_hi;

  function automatic logic signed [DATA_W-1:0] mul_low(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [2*DATA_W-1:0] prod;
    prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    return prod[DATA_W-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] alu_fn(
    input logic [3:0]               op,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic [DATA_W-1:0]        ldata
  );
    logic signed [DATA_W-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_MUL:  r = mul_low(a, b);
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_LW:   r = ldata;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Fetch and decode
  always_comb begin
    instr  = imem[pc];
    imm    = instr[31:16];
    opcode = instr[15:12];
    rd     = instr[11:8];
    rs2    = instr[7:4];
    rs1    = instr[3:0];
  end

  // Register read (R0 hardwired to zero), address generation, memory read and ALU
  always_comb begin
    op_a           = (rs1 == 4'd0) ? '0 : regs[rs1];
    op_b           = (rs2 == 4'd0) ? '0 : regs[rs2];
    eff_addr       = op_a + imm;
    dmem_idx       = eff_addr[DM_W-1:0];
    unused_addr_hi = ^eff_addr[DATA_W-1:DM_W];
    mem_rdata      = dmem[dmem_idx];
    alu_result     = alu_fn(opcode, op_a, op_b, mem_rdata);
    rf_we          = (opcode <= OP_LW) && (rd != 4'd0);
    mem_we         = (opcode == OP_SW);
  end

  // Retire: PC, register file and data memory all commit on the same edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= '0;
    end else if (pc == PC_W'(IMEM_DEPTH - 1)) begin
      pc <= '0;
    end else begin
      pc <= pc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (rf_we) begin
      regs[rd] <= alu_result;
    end
  end

  // Data memory keeps its contents through reset; only the store is suppressed.
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      dmem[dmem_idx] <= op_b;
    end
  end

endmodule

// File: tb/tb_gpu_sc_top.sv
// Bench for gpu_sc_top: directed programs plus a random program checked cycle by cycle
// against an instruction-level model of the ISA.
module tb_gpu_sc_top;

  logic clk;
  logic reset;

  int checks = 0;
  int errors = 0;

  bit [31:0] m_imem [256];
  bit [15:0] m_regs [16];
  bit [15:0] m_dmem [256];
  int        m_pc;

  gpu_sc_top dut (
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ISA semantics with plain integer arithmetic modulo 2^16.
  function automatic int model_alu(input int op, input longint a, input longint b);
    case (op)
      0:       return int'((a + b) % 65536);
      1:       return int'((a - b + 65536) % 65536);
      2:       return int'((a * b) % 65536);
      3:       return int'(a & b);
      4:       return int'(a | b);
      5:       return int'(a ^ b);
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    bit [31:0] w;
    int op, rd, rs2, rs1, imm, a, b, addr, res;
    w   = m_imem[m_pc];
    imm = int'(w[31:16]);
    op  = int'(w[15:12]);
    rd  = int'(w[11:8]);
    rs2 = int'(w[7:4]);
    rs1 = int'(w[3:0]);
    a   = (rs1 == 0) ? 0 : int'(m_regs[rs1]);
    b   = (rs2 == 0) ? 0 : int'(m_regs[rs2]);
    addr = ((a + imm) % 65536) % 256;
    res  = (op == 6) ? int'(m_dmem[addr]) : model_alu(op, a, b);
    if (op == 7) m_dmem[addr] = b[15:0];
    if (op <= 6 && rd != 0) m_regs[rd] = res[15:0];
    m_pc = (m_pc + 1) % 256;
  endtask

  task automatic load_word(input int addr, input bit [31:0] w);
    dut.imem[addr] = w;
    m_imem[addr]   = w;
  endtask

  task automatic set_reg(input int r, input bit [15:0] v);
    dut.regs[r] = v;
    m_regs[r]   = v;
  endtask

  task automatic set_mem(input int a, input bit [15:0] v);
    dut.dmem[a] = v;
    m_dmem[a]   = v;
  endtask

  // Holds reset low across one edge and checks the cleared state; returns at a negedge, reset still low.
  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    m_pc = 0;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    check("reset_pc", 16'(dut.pc), 16'h0);
    for (int i = 0; i < 16; i++) check($sformatf("reset_r%0d", i), dut.regs[i], 16'h0);
  endtask

  // Per cycle: compare fetch/decode/operand/ALU visibility against the model, then advance.
  task automatic run_cycles(input int n);
    bit [31:0] w;
    int op, rd, rs2, rs1, a, b;
    for (int k = 0; k < n; k++) begin
      #1;
      w   = m_imem[m_pc];
      op  = int'(w[15:12]);
      rd  = int'(w[11:8]);
      rs2 = int'(w[7:4]);
      rs1 = int'(w[3:0]);
      a   = (rs1 == 0) ? 0 : int'(m_regs[rs1]);
      b   = (rs2 == 0) ? 0 : int'(m_regs[rs2]);
      check("pc", 16'(dut.pc), 16'(m_pc));
      check("opcode", 16'(dut.opcode), 16'(op));
      check("op_a", dut.op_a, 16'(a));
      check("op_b", dut.op_b, 16'(b));
      check("rf_we", 16'(dut.rf_we), 16'((op <= 6 && rd != 0) ? 1 : 0));
      if (op <= 5) check("alu_result", dut.alu_result, 16'(model_alu(op, a, b)));
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic compare_state(input string ph);
    for (int i = 0; i < 16; i++) check($sformatf("%s_r%0d", ph, i), dut.regs[i], m_regs[i]);
    for (int i = 0; i < 256; i++) check($sformatf("%s_m%0d", ph, i), dut.dmem[i], m_dmem[i]);
  endtask

  initial begin
    bit [31:0] w;
    int n;
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      load_word(i, 32'h0);
      set_mem(i, 16'h0);
    end

    // R-type, store, load program
    do_reset();
    load_word(0,  32'h00000312);
    load_word(1,  32'h00001412);
    load_word(2,  32'h00002522);
    load_word(3,  32'h00003621);
    load_word(4,  32'h00004721);
    load_word(5,  32'h00005821);
    load_word(6,  32'h00007030);
    load_word(7,  32'h00017050);
    load_word(8,  32'h00027070);
    load_word(9,  32'h00006900);
    load_word(10, 32'h00016A00);
    load_word(11, 32'h00026B00);
    reset = 1'b1;
    set_reg(1, 16'd5);
    set_reg(2, 16'd10);
    run_cycles(12);
    check("add_r3", dut.regs[3], 16'd15);
    check("sub_r4", dut.regs[4], 16'd5);
    check("mul_r5", dut.regs[5], 16'd100);
    check("and_r6", dut.regs[6], 16'd0);
    check("or_r7",  dut.regs[7], 16'd15);
    check("xor_r8", dut.regs[8], 16'd15);
    check("sw_m0",  dut.dmem[0], 16'd15);
    check("sw_m1",  dut.dmem[1], 16'd100);
    check("sw_m2",  dut.dmem[2], 16'd15);
    check("lw_r9",  dut.regs[9], 16'd15);
    check("lw_r10", dut.regs[10], 16'd100);
    check("lw_r11", dut.regs[11], 16'd15);
    check("r1_kept", dut.regs[1], 16'd5);
    check("pc_12",  16'(dut.pc), 16'd12);
    compare_state("p1");

    // Wrap-around arithmetic, R0 write discard, NOP
    do_reset();
    for (int i = 0; i < 12; i++) load_word(i, 32'h0);
    load_word(0, 32'h00000321);
    load_word(1, 32'h00001420);
    load_word(2, 32'h000025CC);
    load_word(3, 32'h00000021);
    load_word(4, 32'h0000F123);
    reset = 1'b1;
    set_reg(1, 16'hFFFF);
    set_reg(2, 16'h0002);
    set_reg(12, 16'h0100);
    run_cycles(5);
    check("wrap_add", dut.regs[3], 16'h0001);
    check("wrap_sub", dut.regs[4], 16'hFFFE);
    check("wrap_mul", dut.regs[5], 16'h0000);
    check("r0_zero",  dut.regs[0], 16'h0000);
    check("nop_r1",   dut.regs[1], 16'hFFFF);
    check("pc_5",     16'(dut.pc), 16'd5);
    compare_state("p2");

    // Random program with PC wrap and a mid-run reset
    do_reset();
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      w[31:16] = 16'($urandom_range(0, 511));
      load_word(i, w);
      set_mem(i, 16'($urandom));
    end
    reset = 1'b1;
    for (int i = 1; i < 16; i++) set_reg(i, 16'($urandom));
    run_cycles(300);
    n = (5 - m_pc + 256) % 256;
    run_cycles(n);
    #1;
    check("pre_reset_pc", 16'(dut.pc), 16'd5);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    m_pc = 0;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    check("midrst_pc", 16'(dut.pc), 16'd0);
    compare_state("midrst");
    reset = 1'b1;
    run_cycles(60);
    compare_state("p3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
